keypad_event_gen: RTL

Debounced, edge-triggered, auto-repeating key event generator for the calculator front panel. It sits between the raw push-button inputs and the expression-buffer data structure. It converts held or bouncing buttons into single-cycle events: a symbol code on `dataIn` with an `insert` pulse, or one of the four control pulses. Held editing keys auto-repeat at a programmable rate, and N-key lockout guarantees exactly one event source at a time.

---
 rtl/keypad_event_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_event_gen.sv
// keypad_event_gen: debounced, edge-triggered key event generator for the
// calculator front panel. It turns raw buttons into single-cycle events, with
// N-key lockout.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN. When defined, held del/ptrLeft/
// ptrRight keys auto-repeat after REPEAT_DELAY and then every REPEAT_RATE cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | armed (K == 0 seen); the first debounced key fires an event
// HELD     | key A locked; waiting for the repeat delay or for its release
// REPEAT   | key A locked; an event fires every REPEAT_RATE cycles
// WAIT_REL | event done; waiting for every key to be released
module keypad_event_gen #(
  parameter int WIDTH        = 8,
  parameter int BUTTONS      = 26,
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BUTTONS-1:0] b,
  input  logic               del,
  input  logic               ptrLeft,
  input  logic               ptrRight,
  input  logic               eval,
  output logic [WIDTH-1:0]   dataIn,
  output logic               insert,
  output logic               del_pulse,
  output logic               ptrLeft_pulse,
  output logic               ptrRight_pulse,
  output logic               eval_pulse,
  output logic               key_held
);

  localparam int N      = BUTTONS + 4;
  localparam int AW     = $clog2(N);
  localparam int CMAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int CMAX   = (CMAX_A > REPEAT_RATE) ? CMAX_A : REPEAT_RATE;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [AW-1:0] IDX_DEL  = AW'(BUTTONS);
  localparam logic [AW-1:0] IDX_PL   = AW'(BUTTONS + 1);
  localparam logic [AW-1:0] IDX_PR   = AW'(BUTTONS + 2);
  localparam logic [AW-1:0] IDX_EVAL = AW'(BUTTONS + 3);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT, WAIT_REL} state_t;

  logic [N-1:0]  l_raw, sync1, s_vec, k_vec;
  logic [CW-1:0] d_cnt;
  logic [AW-1:0] first_idx, a_reg, a_nx, fire_idx;
  logic          fire;
  logic          ins_nx, del_nx, pl_nx, pr_nx, ev_nx;
  state_t        state, state_nx;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] r_cnt, r_nx;
  logic          rep_a;
  assign rep_a = (a_reg == IDX_DEL) || (a_reg == IDX_PL) || (a_reg == IDX_PR);
`endif

  assign l_raw    = {eval, ptrRight, ptrLeft, del, b};
  assign key_held = (state != IDLE);

  function automatic logic [7:0] sym_code(input logic [AW-1:0] idx);
    int unsigned v;
    v = 32'(idx);
    if (v < 16)       sym_code = 8'(v);
    else if (v == 16) sym_code = 8'hDD;
    else if (v == 17) sym_code = 8'hC0;
    else if (v == 18) sym_code = 8'hC1;
    else if (v < 26)  sym_code = 8'(32'hF0 + v - 19);
    else              sym_code = 8'(v);
  endfunction

  // Two-flop synchroniser; one shared debounce counter; K loads once S has held still.
  // D clears on the edge where S changes, so K follows 1+DEB_CYCLES edges after first sampling.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      s_vec <= '0;
      d_cnt <= '0;
      k_vec <= '0;
    end else begin
      sync1 <= l_raw;
      s_vec <= sync1;
      if (sync1 != s_vec) begin
        d_cnt <= '0;
      end else begin
        if (d_cnt != CW'(DEB_CYCLES)) d_cnt <= d_cnt + 1'b1;
        if (d_cnt >= CW'(DEB_CYCLES - 1)) k_vec <= s_vec;
      end
    end
  end

  // Lowest set bit of K wins, so symbols take priority over the control keys.
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (k_vec[i]) first_idx = AW'(i);
    end
  end

  // Next-state logic: locks onto key A and decides when an event fires.
  always_comb begin
    state_nx = state;
    a_nx     = a_reg;
    fire     = 1'b0;
    fire_idx = a_reg;
`ifdef KEYPAD_AUTOREPEAT_EN
    r_nx     = r_cnt;
`endif
    case (state)
      IDLE: begin
        if (k_vec != '0) begin
          a_nx     = first_idx;
          fire     = 1'b1;
          fire_idx = first_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
          r_nx     = '0;
          state_nx = HELD;
`else
          state_nx = WAIT_REL;
`endif
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      HELD: begin
        if (!k_vec[a_reg]) begin
          r_nx     = '0;
          state_nx = WAIT_REL;
        end else if (rep_a) begin
          if (r_cnt == CW'(REPEAT_DELAY - 1)) begin
            fire     = 1'b1;
            r_nx     = '0;
            state_nx = REPEAT;
          end else begin
            r_nx = r_cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        // Release is checked first so a key let go on the expiry cycle does not repeat.
        if (!k_vec[a_reg]) begin
          r_nx     = '0;
          state_nx = WAIT_REL;
        end else if (r_cnt == CW'(REPEAT_RATE - 1)) begin
          fire = 1'b1;
          r_nx = '0;
        end else begin
          r_nx = r_cnt + 1'b1;
        end
      end
`endif
      WAIT_REL: begin
        if (k_vec == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Decode the firing line into exactly one event pulse.
  always_comb begin
    ins_nx = fire && (fire_idx < IDX_DEL);
    del_nx = fire && (fire_idx == IDX_DEL);
    pl_nx  = fire && (fire_idx == IDX_PL);
    pr_nx  = fire && (fire_idx == IDX_PR);
    ev_nx  = fire && (fire_idx == IDX_EVAL);
  end

  // State, locked index and registered event outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      a_reg          <= '0;
      dataIn         <= '0;
      insert         <= 1'b0;
      del_pulse      <= 1'b0;
      ptrLeft_pulse  <= 1'b0;
      ptrRight_pulse <= 1'b0;
      eval_pulse     <= 1'b0;
    end else begin
      state          <= state_nx;
      a_reg          <= a_nx;
      insert         <= ins_nx;
      del_pulse      <= del_nx;
      ptrLeft_pulse  <= pl_nx;
      ptrRight_pulse <= pr_nx;
      eval_pulse     <= ev_nx;
      if (ins_nx) dataIn <= WIDTH'(sym_code(fire_idx));
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Repeat timer: counts up while a repeatable key is held.
  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= r_nx;
  end
`endif

endmodule
